softmax_outp_writer: RTL and testbench

Write-back stage directly downstream of the softmax core. Captures the NUM-lane result vector that the core presents on each cycle its `done` window is high. Buffers each vector in a small FWFT FIFO to absorb memory-port backpressure. Writes the vectors to consecutive addresses of the on-chip output memory, starting from a latched base, and pulses `complete` once the last vector has been written.

---
 rtl/softmax_outp_writer_if.sv | 24 ++
 rtl/softmax_outp_writer.sv | 124 ++++++++++++
 tb/tb_softmax_outp_writer.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/softmax_outp_writer_if.sv
// Write-back bus for softmax_outp_writer: producer side (softmax result vector)
// and memory write port. The DUT uses the slave modport.
interface softmax_outp_writer_if #(
   parameter int DATAWIDTH = 16,
   parameter int NUM       = 4,
   parameter int ADDRSIZE  = 8
) ();
   logic                      outp_valid;
   logic [DATAWIDTH*NUM-1:0]  outp;
   logic                      mem_wr_ready;
   logic                      mem_wr_en;
   logic [ADDRSIZE-1:0]       mem_wr_addr;
   logic [DATAWIDTH*NUM-1:0]  mem_wr_data;

   modport master (
      output outp_valid, outp, mem_wr_ready,
      input  mem_wr_en, mem_wr_addr, mem_wr_data
   );

   modport slave (
      input  outp_valid, outp, mem_wr_ready,
      output mem_wr_en, mem_wr_addr, mem_wr_data
   );
endinterface

// File: rtl/softmax_outp_writer.sv
// Softmax write-back: FWFT FIFO between the softmax core and the output memory.
// Define SOFTMAX_WB_CLAMP_EN to clamp each lane into [0, ONE_VAL] before buffering.
module softmax_outp_writer #(
   parameter int                   DATAWIDTH = 16,
   parameter int                   NUM       = 4,
   parameter int                   ADDRSIZE  = 8,
   parameter int                   DEPTH     = 4,
   parameter logic [DATAWIDTH-1:0] ONE_VAL   = 16'h3C00
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                init,
   input  logic [ADDRSIZE-1:0] out_start_addr,
   softmax_outp_writer_if.slave wb,
   output logic                busy,
   output logic                complete,
   output logic                overflow,
   output logic [ADDRSIZE-1:0] word_count
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);

`ifdef SOFTMAX_WB_CLAMP_EN
   localparam bit CLAMP_EN = 1'b1;
`else
   localparam bit CLAMP_EN = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   logic [NUM-1:0][DATAWIDTH-1:0] lane_in, lane_out;
   logic [NUM*DATAWIDTH-1:0]      fifo_mem [DEPTH];
   logic [AW-1:0]                 rd_ptr, wr_ptr;
   logic [AW:0]                   count;
   logic                          empty, full, push_req, push, pop, drain_empty;
   state_t                        state_q, state_d;

   assign lane_in = wb.outp;

   for (genvar g = 0; g < NUM; g++) begin : g_lane
      logic [DATAWIDTH-1:0] lane_q;
      always_comb begin
         lane_q = lane_in[g];
         if (CLAMP_EN) begin
            if (lane_in[g][DATAWIDTH-1])  lane_q = '0;
            else if (lane_in[g] > ONE_VAL) lane_q = ONE_VAL;
         end
      end
      assign lane_out[g] = lane_q;
   end

   assign empty    = (count == '0);
   assign full     = (count == FULL_CNT);
   assign pop      = !empty && wb.mem_wr_ready && !init;
   assign push_req = wb.outp_valid && !init;
   // The core cannot stall, so a full FIFO only takes the vector if a slot frees this cycle.
   assign push     = push_req && (!full || pop);

   assign wb.mem_wr_en   = !empty;
   assign wb.mem_wr_data = empty ? '0 : fifo_mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= lane_out;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr         <= '0;
         wr_ptr         <= '0;
         count          <= '0;
         wb.mem_wr_addr <= '0;
         word_count     <= '0;
         overflow       <= 1'b0;
      end else if (init) begin
         rd_ptr         <= '0;
         wr_ptr         <= '0;
         count          <= '0;
         wb.mem_wr_addr <= out_start_addr;
         word_count     <= '0;
         overflow       <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) begin
            rd_ptr         <= rd_ptr + 1'b1;
            wb.mem_wr_addr <= wb.mem_wr_addr + 1'b1;
            if (word_count != '1) word_count <= word_count + 1'b1;
         end
         if (push && !pop)      count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
         if (push_req && !push) overflow <= 1'b1;
      end
   end

   // FIFO is empty after this edge; valid is low whenever this matters, so no push.
   assign drain_empty = empty || (count == ONE_CNT && pop);

   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // RUN with valid low and nothing left to write skips the empty DRAIN cycle,
   // so complete always lands the cycle after the final write.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:       if (push) state_d = RUN;
         RUN, DRAIN: begin
            if (wb.outp_valid)    state_d = RUN;
            else if (drain_empty) state_d = DONE;
            else                  state_d = DRAIN;
         end
         DONE:       state_d = push ? RUN : IDLE;
         default:    state_d = IDLE;
      endcase
      if (init) state_d = IDLE;
   end

   always_comb begin
      busy     = (state_q != IDLE);
      complete = (state_q == DONE);
   end
endmodule

// File: tb/tb_softmax_outp_writer.sv
// Randomized bench for softmax_outp_writer against a queue-based reference model.
module tb_softmax_outp_writer;
   localparam int DW = 16, N = 4, AW = 8, DEPTH = 4;
   localparam int VW = DW * N;

   logic          clk = 1'b0;
   logic          reset, init;
   logic [AW-1:0] base;
   logic          busy, complete, overflow;
   logic [AW-1:0] word_count;

   softmax_outp_writer_if #(.DATAWIDTH(DW), .NUM(N), .ADDRSIZE(AW)) wb ();

   softmax_outp_writer #(
      .DATAWIDTH(DW), .NUM(N), .ADDRSIZE(AW), .DEPTH(DEPTH), .ONE_VAL(16'h3C00)
   ) dut (
      .clk(clk), .reset(reset), .init(init), .out_start_addr(base), .wb(wb),
      .busy(busy), .complete(complete), .overflow(overflow), .word_count(word_count)
   );

   always #5 clk = ~clk;

   // reference model state
   logic [VW-1:0] mq[$];
   logic [AW-1:0] m_addr, m_cnt;
   bit            m_ovf, m_active, m_cpl, m_clean;
   int            n_chk = 0, n_fail = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [VW-1:0] ref_vec(input logic [VW-1:0] v);
      logic [VW-1:0] r;
      logic [DW-1:0] l;
      r = v;
`ifdef SOFTMAX_WB_CLAMP_EN
      for (int i = 0; i < N; i++) begin
         l = v[DW*i +: DW];
         if (l[DW-1]) l = '0;
         else if (l > 16'h3C00) l = 16'h3C00;
         r[DW*i +: DW] = l;
      end
`endif
      return r;
   endfunction

   function automatic logic [VW-1:0] rnd_vec();
      return {$urandom, $urandom};
   endfunction

   // One clock: check outputs against the model, drive inputs, advance the model.
   task automatic step(input bit rst, input bit ini, input logic [AW-1:0] b,
                       input bit v, input bit r, input logic [VW-1:0] d);
      bit pop, push;
      @(negedge clk);
      chk("wr_en", wb.mem_wr_en, mq.size() != 0);
      if (mq.size() != 0) chk("wr_data", wb.mem_wr_data, mq[0]);
      else if (m_clean)   chk("wr_data_rst", wb.mem_wr_data, '0);
      chk("wr_addr", wb.mem_wr_addr, m_addr);
      chk("busy", busy, m_active || m_cpl);
      chk("complete", complete, m_cpl);
      chk("overflow", overflow, m_ovf);
      chk("word_count", word_count, m_cnt);
      reset = rst; init = ini; base = b;
      wb.outp_valid = v; wb.outp = d; wb.mem_wr_ready = r;
      if (rst || ini) begin
         mq.delete();
         m_addr = rst ? '0 : b;
         m_cnt = '0; m_ovf = 0; m_active = 0; m_cpl = 0;
         if (rst) m_clean = 1;
      end else begin
         pop  = (mq.size() != 0) && r;
         push = v && (mq.size() < DEPTH || pop);
         if (v && !push) m_ovf = 1;
         if (pop) begin
            void'(mq.pop_front());
            m_addr++;
            if (m_cnt != '1) m_cnt++;
         end
         if (push) begin
            mq.push_back(ref_vec(d));
            m_active = 1;
            m_clean = 0;
         end
         m_cpl = m_active && !v && mq.size() == 0;
         if (m_cpl) m_active = 0;
      end
   endtask

   task automatic idle(input int n, input bit r);
      for (int i = 0; i < n; i++) step(0, 0, base, 0, r, '0);
   endtask

   task automatic do_init(input logic [AW-1:0] b);
      step(0, 1, b, 0, 1, '0);
   endtask

   initial begin
      reset = 1; init = 0; base = '0;
      wb.outp_valid = 0; wb.outp = '0; wb.mem_wr_ready = 0;
      repeat (2) @(posedge clk);
      mq.delete();
      m_addr = '0; m_cnt = '0; m_ovf = 0; m_active = 0; m_cpl = 0; m_clean = 1;
      step(1, 0, '0, 0, 0, '0);
      idle(2, 0);

      // basic: 5 back-to-back vectors from 0x10
      do_init(8'h10);
      for (int i = 0; i < 5; i++) step(0, 0, base, 1, 1, rnd_vec());
      idle(4, 1);

      // backpressure: fill to DEPTH while stalled, then release
      do_init(8'h20);
      for (int i = 0; i < 4; i++) step(0, 0, base, 1, 0, rnd_vec());
      idle(2, 0);
      idle(7, 1);

      // overflow: 6 vectors into a stalled 4-deep FIFO
      do_init(8'h30);
      for (int i = 0; i < 6; i++) step(0, 0, base, 1, 0, rnd_vec());
      idle(8, 1);

      // address wrap
      do_init(8'hFE);
      for (int i = 0; i < 3; i++) step(0, 0, base, 1, 1, rnd_vec());
      idle(4, 1);

      // clamp corner lanes (lane 0 in LSBs)
      do_init(8'h80);
      step(0, 0, base, 1, 1, 64'h7C00_3800_BC00_3C01);
      step(0, 0, base, 1, 1, 64'h3C00_0000_8000_FFFF);
      idle(4, 1);

      // abort: init after 2 writes with 2 vectors still buffered
      do_init(8'h40);
      for (int i = 0; i < 3; i++) step(0, 0, base, 1, 1, rnd_vec());
      step(0, 0, base, 1, 0, rnd_vec());
      do_init(8'h50);
      idle(3, 1);

      // reset mid-drain
      do_init(8'h60);
      for (int i = 0; i < 4; i++) step(0, 0, base, 1, 0, rnd_vec());
      step(0, 0, base, 0, 1, '0);
      step(1, 0, base, 0, 1, '0);
      idle(2, 1);

      // randomized traffic
      do_init(8'h00);
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 63) == 0)
            step(0, 1, AW'($urandom), $urandom_range(0, 1) == 1, 1, rnd_vec());
         else
            step(0, 0, base, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, rnd_vec());
      end
      idle(10, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
